// File: rtl/modmul_2011_seq_pkg.sv
// Shared constants, FSM state type, operand payload and digit helper for the
// mod-2011 channel multiplier.
package mod2011_pkg;

  localparam int unsigned MODULUS    = 2011;
  localparam int unsigned OPERAND_W  = 11;
  localparam int unsigned DIGIT_W    = 3;
  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned NUM_PAIRS  = 16;
  localparam int unsigned CNT_W      = 4;
  localparam int unsigned SUM_W      = OPERAND_W + 1;
  localparam int unsigned IDX_W      = 2;
  localparam int unsigned K_W        = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Captured operand pair
  typedef struct packed {
    logic [OPERAND_W-1:0] a;
    logic [OPERAND_W-1:0] b;
  } operands_t;

  // Digit idx of an operand; the top digit only has two real bits and
  // comes out zero-extended because the shift brings in zeros.
  function automatic logic [DIGIT_W-1:0] digit_of(input logic [OPERAND_W-1:0] operand,
                                                  input logic [IDX_W-1:0]     idx);
    logic [OPERAND_W-1:0] sh;
    sh = operand >> (DIGIT_W * 32'(idx));
    return sh[DIGIT_W-1:0];
  endfunction

endpackage

// File: rtl/modmul_2011_seq_if.sv
// Operand/result handshake bundle for the mod-2011 multiplier.
//   master: operand source + result sink (drives in_*, abort, out_ready)
//   slave : the multiplier (drives in_ready, out_*, busy)
interface modmul_2011_seq_if;
  import mod2011_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [OPERAND_W-1:0] in_a;
  logic [OPERAND_W-1:0] in_b;
  logic                 abort;
  logic                 out_valid;
  logic                 out_ready;
  logic [OPERAND_W-1:0] out_result;
  logic                 busy;

  modport master (
    output in_valid, in_a, in_b, abort, out_ready,
    input  in_ready, out_valid, out_result, busy
  );

  modport slave (
    input  in_valid, in_a, in_b, abort, out_ready,
    output in_ready, out_valid, out_result, busy
  );

endinterface

// File: rtl/modmul_2011_seq_mult.sv
// Weighted 3x3 digit product: r = (da * db * 8^k) mod 2011, purely combinational.
// Ports: da, db digits; k weight exponent (0..6 used); r reduced term.
module mult_3x3_weighted
  import mod2011_pkg::*;
(
  input  logic [DIGIT_W-1:0]   da,
  input  logic [DIGIT_W-1:0]   db,
  input  logic [K_W-1:0]       k,
  output logic [OPERAND_W-1:0] r
);

  localparam int unsigned PROD_W = 2 * DIGIT_W;
  localparam int unsigned FULL_W = 17;

  logic [PROD_W-1:0]    prod;
  logic [OPERAND_W-1:0] w;
  logic [FULL_W-1:0]    full;

  // 8^k already reduced mod 2011, so every product stays within 17 bits
  // and the whole block flattens into a small LUT per weight.
  always_comb begin
    prod = PROD_W'(da) * PROD_W'(db);
    w    = 11'd0;
    unique case (k)
      3'd0: w = 11'd1;
      3'd1: w = 11'd8;
      3'd2: w = 11'd64;
      3'd3: w = 11'd512;
      3'd4: w = 11'd74;
      3'd5: w = 11'd592;
      3'd6: w = 11'd714;
      3'd7: w = 11'd1690;
      default: w = 11'd0;
    endcase
    full = FULL_W'(prod) * FULL_W'(w);
    r    = OPERAND_W'(full % FULL_W'(MODULUS));
  end

endmodule

// File: rtl/modmul_2011_seq.sv
// Sequential (a*b) mod 2011: walks the 16 digit pairs one per cycle through a
// single weighted digit-product unit and accumulates with a mod-2011 adder.
// Ports: clk, rst_n (async active-low), bus (slave side of modmul_2011_seq_if).
module modmul_2011_seq
  import mod2011_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  modmul_2011_seq_if.slave   bus
);

  state_e               state_q;
  logic [CNT_W-1:0]     cnt_q;
  operands_t            ops_q;
  logic [OPERAND_W-1:0] acc_q;
  logic [OPERAND_W-1:0] acc_d;
  logic [OPERAND_W-1:0] out_result_q;
  logic                 out_valid_q;
  logic                 in_ready_q;
  logic                 busy_q;

  logic [DIGIT_W-1:0]   da;
  logic [DIGIT_W-1:0]   db;
  logic [K_W-1:0]       k;
  logic [OPERAND_W-1:0] term;
  logic [SUM_W-1:0]     sum;

  // Pair selection: i = cnt[3:2], j = cnt[1:0], weight k = i + j
  always_comb begin
    da = digit_of(ops_q.a, cnt_q[3:2]);
    db = digit_of(ops_q.b, cnt_q[1:0]);
    k  = K_W'(cnt_q[3:2]) + K_W'(cnt_q[1:0]);
  end

  mult_3x3_weighted u_mult (
    .da (da),
    .db (db),
    .k  (k),
    .r  (term)
  );

  // acc and term are both < 2011, so one conditional subtract reduces the sum
  always_comb begin
    sum   = SUM_W'(acc_q) + SUM_W'(term);
    acc_d = (sum >= SUM_W'(MODULUS)) ? OPERAND_W'(sum - SUM_W'(MODULUS))
                                     : OPERAND_W'(sum);
  end

  // Controller FSM with registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      ops_q        <= '0;
      acc_q        <= '0;
      out_result_q <= '0;
      out_valid_q  <= 1'b0;
      in_ready_q   <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          // abort wins over a simultaneous in_valid
          if (!bus.abort && bus.in_valid) begin
            ops_q      <= '{a: bus.in_a, b: bus.in_b};
            acc_q      <= '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= RUN;
          end
        end
        RUN: begin
          if (bus.abort) begin
            acc_q      <= '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= IDLE;
          end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(NUM_PAIRS - 1)) begin
              out_result_q <= acc_d;
              out_valid_q  <= 1'b1;
              state_q      <= DONE;
            end
          end
        end
        DONE: begin
          if (bus.abort) begin
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = out_result_q;
  assign bus.busy       = busy_q;

endmodule

// File: doc/modmul_2011_seq.md
Name: modmul_2011_seq

Overview:
Sequential modular multiplier for the mod-2011 channel. Computes out_result = (in_a * in_b) mod 2011 by splitting each 11-bit operand into four 3-bit digits. It steps through all 16 digit pairs, one per cycle, through a single shared weighted 3x3 digit-product unit, and accumulates the terms with a mod-2011 adder. It sits between the channel's operand source and result sink, using valid/ready handshakes on both sides.

Parameters:
- MODULUS, 2011, channel modulus. Tied to the digit-product LUT contents; no other value is supported.
- OPERAND_W, 11, operand and result width.
- DIGIT_W, 3, digit width. Gives 4 digits; the top digit holds bits [10:9] and is zero-extended.

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept operands
- in_a  in  11  operand A; any value 0..2047 is accepted
- in_b  in  11  operand B; any value 0..2047 is accepted
- abort  in  1  synchronous cancel of the operation in flight
- out_valid  out  1  result valid
- out_ready  in  1  sink accepts the result
- out_result  out  11  (in_a*in_b) mod 2011, always in the range 0..2010
- busy  out  1  high in RUN or DONE

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, in_ready=1, out_valid=0, out_result=0, busy=0, acc=0, pair counter=0, operand registers=0.
- State machine, IDLE:
  - in_ready=1.
  - When in_valid is high, capture in_a and in_b, clear acc=0 and cnt=0, go to RUN.
- State machine, RUN (16 cycles):
  - in_ready=0.
  - cnt is 4 bits. Digit indices are i=cnt[3:2] and j=cnt[1:0]; weight k=i+j, range 0..6.
  - Each cycle:
    - term = (a_i * b_j * 2^(3k)) mod 2011, from the sub-module;
    - s = acc + term, computed as a 12-bit value;
    - acc <= (s >= 2011) ? s - 2011 : s;
    - cnt <= cnt + 1.
  - On the cycle with cnt==15: update acc, load out_result with the final acc, set out_valid=1, go to DONE.
- State machine, DONE:
  - out_valid=1. out_result is held stable until out_ready is high.
  - On out_valid && out_ready: out_valid <= 0, go to IDLE.
  - in_ready=0 in DONE, so there is no same-cycle reload. Back-to-back throughput is 1 result per 18 cycles.
- Latency: operands accepted on edge T; out_valid rises after edge T+16.
- abort:
  - In RUN or DONE: return to IDLE next edge with out_valid=0 and acc cleared. out_result keeps its last value.
  - In IDLE: ignored, and it has priority over in_valid in the same cycle, so no capture occurs.
- Invariant: acc stays in 0..2010 at all times, so a single conditional subtract is sufficient.
- out_result changes only on the RUN→DONE transition or on reset.
- in_a/in_b changing while not in IDLE has no effect.
- rst_n asserted mid-RUN: immediately returns every register to its reset value, and the partial result is discarded.

Decomposition:
- Package mod2011_pkg holds:
  - constants MODULUS=2011, OPERAND_W=11, DIGIT_W=3, NUM_DIGITS=4, NUM_PAIRS=16;
  - state enum {IDLE, RUN, DONE};
  - a function digit_of(operand, idx).
- Sub-module mult_3x3_weighted: purely combinational.
  - Inputs: da[2:0], db[2:0], k[2:0]. Output: r[10:0] = (da*db*8^k) mod 2011.
  - Implemented as a synthesized LUT per weight, in the same style as the channel's existing 3x3 product units.
- The controller instantiates exactly one instance and holds the FSM, counter, operand registers and mod adder.

Test Plan:
- in_a=0, in_b=1234 → out_result=0, with out_valid exactly 16 edges after acceptance.
- in_a=2010, in_b=2010 → out_result=1. in_a=2047, in_b=2047 → out_result=1296 (unreduced inputs).
- in_a=1000, in_b=3 → 989. in_a=1, in_b=2010 → 2010. Then sweep 2000 random pairs against a (a*b)%2011 reference model.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid → out_result and out_valid stay stable, in_ready stays 0. Releasing out_ready gives a one-cycle handshake, then in_ready=1.
- abort pulsed at RUN cycle 7 → IDLE next edge, out_valid never rises. A following in_a=5, in_b=7 → 35.
- rst_n pulsed low asynchronously mid-RUN, outside any clock edge → outputs reach their reset values immediately. The next operation, in_a=2011, in_b=9, gives 0.
